regfile_mp: RTL and testbench

- Parametrised multi-port register file for the next-generation dual-issue core pipeline.
- Provides NRD asynchronous read ports and two synchronous write ports, with a deterministic write priority and optional same-cycle write-to-read bypass.
- Register 0 can be hard-wired to zero.
- Contents are cleared after reset by a one-entry-per-cycle init sequencer, so no wide single-cycle reset fan-out is needed.

---
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD asynchronous read ports and two write ports.
// Port 1 wins same-address write collisions. Same-cycle write-to-read bypass
// and a hard-wired zero register are optional. After reset, an init sequencer
// clears one entry per cycle, and ready rises when every entry has been cleared.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  output logic                  ready,
  output logic                  wr_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                run;
  logic                eff0, eff1;

  // Write qualification: writes take effect only in RUN, and never to entry 0 when it is hard-wired to zero
  always_comb begin
    run         = (state_q == ST_RUN);
    eff0        = run && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    eff1        = run && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    wr_conflict = eff0 && eff1 && (wa0 == wa1);
  end

  // Init sequencer next-state: walk clr_cnt over every entry, then enter RUN
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Array next value: a clear during INIT, otherwise port 0 then port 1, so port 1 wins collisions
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_INIT) begin
      mem_d[clr_cnt_q] = '0;
    end else begin
      if (eff0) mem_d[wa0] = wd0;
      if (eff1) mem_d[wa1] = wd1;
    end
  end

  // Array storage; rst leaves contents alone, and the init sequencer clears them instead
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read lanes: zero register, then port-1 bypass, then port-0 bypass, then stored value
  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra    = '0;
    rdata = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      if (run) begin
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rdata[k*DATA_W +: DATA_W] = '0;
        end else if ((BYPASS != 0) && eff1 && (wa1 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wd1;
        end else if ((BYPASS != 0) && eff0 && (wa0 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wd0;
        end else begin
          rdata[k*DATA_W +: DATA_W] = mem_q[ra];
        end
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, BYPASS=0 build and ZERO_REG=0 build share stimulus.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, we0, we1;
  logic [AW-1:0]  wa0, wa1;
  logic [DW-1:0]  wd0, wd1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_nb, rdata_nz;
  logic ready, ready_nb, ready_nz;
  logic conf, conf_nb, conf_nz;

  int n_pass  = 0;
  int n_total = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready), .wr_conflict(conf));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready_nb), .wr_conflict(conf_nb));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(0), .BYPASS(1)) u_nz (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ready(ready_nz), .wr_conflict(conf_nz));

  typedef struct packed {
    logic           we0;
    logic [AW-1:0]  wa0;
    logic [DW-1:0]  wd0;
    logic           we1;
    logic [AW-1:0]  wa1;
    logic [DW-1:0]  wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] exp_rd;
    logic           exp_conf;
    logic [DW-1:0]  exp_nb0;
    logic [DW-1:0]  exp_nz0;
    logic           exp_nz_conf;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic e0, input int a0, input logic [DW-1:0] d0,
    input logic e1, input int a1, input logic [DW-1:0] d1,
    input int r0, input int r1, input int r2, input int r3,
    input logic [DW-1:0] x0, input logic [DW-1:0] x1,
    input logic [DW-1:0] x2, input logic [DW-1:0] x3,
    input logic c, input logic [DW-1:0] nb0, input logic [DW-1:0] nz0, input logic nzc);
    vec_t v;
    v.we0 = e0; v.wa0 = AW'(a0); v.wd0 = d0;
    v.we1 = e1; v.wa1 = AW'(a1); v.wd1 = d1;
    v.ra = {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
    v.exp_rd = {x3, x2, x1, x0};
    v.exp_conf = c;
    v.exp_nb0 = nb0;
    v.exp_nz0 = nz0;
    v.exp_nz_conf = nzc;
    return v;
  endfunction

  function automatic logic [NR*AW-1:0] lanes(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Counts cycles until ready, bounded; a timeout shows up as a wrong count
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    vecs[0] = mk(1, 5, 32'h11111111, 1, 6, 32'h22222222, 5, 6, 0, 5,
                 32'h11111111, 32'h22222222, 32'h0, 32'h11111111, 0, 32'h0, 32'h11111111, 0);
    vecs[1] = mk(0, 0, 32'h0, 0, 0, 32'h0, 5, 6, 0, 5,
                 32'h11111111, 32'h22222222, 32'h0, 32'h11111111, 0, 32'h11111111, 32'h11111111, 0);
    vecs[2] = mk(1, 7, 32'hAAAA0000, 1, 7, 32'h0000BBBB, 7, 0, 5, 6,
                 32'h0000BBBB, 32'h0, 32'h11111111, 32'h22222222, 1, 32'h0, 32'h0000BBBB, 1);
    vecs[3] = mk(0, 0, 32'h0, 0, 0, 32'h0, 7, 7, 6, 0,
                 32'h0000BBBB, 32'h0000BBBB, 32'h22222222, 32'h0, 0, 32'h0000BBBB, 32'h0000BBBB, 0);
    vecs[4] = mk(1, 9, 32'h5, 0, 0, 32'h0, 9, 0, 0, 0,
                 32'h5, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h5, 0);
    vecs[5] = mk(1, 9, 32'h6, 0, 0, 32'h0, 9, 9, 7, 5,
                 32'h6, 32'h6, 32'h0000BBBB, 32'h11111111, 0, 32'h5, 32'h6, 0);
    vecs[6] = mk(0, 0, 32'h0, 0, 0, 32'h0, 9, 9, 9, 9,
                 32'h6, 32'h6, 32'h6, 32'h6, 0, 32'h6, 32'h6, 0);
    vecs[7] = mk(1, 0, 32'h1234, 1, 0, 32'hFFFFFFFF, 0, 0, 9, 0,
                 32'h0, 32'h0, 32'h6, 32'h0, 0, 32'h0, 32'hFFFFFFFF, 1);
    vecs[8] = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 5, 6, 7,
                 32'h0, 32'h11111111, 32'h22222222, 32'h0000BBBB, 0, 32'h0, 32'hFFFFFFFF, 0);
    vecs[9] = mk(1, 10, 32'h0000CAFE, 1, 11, 32'h0000BEEF, 10, 11, 10, 11,
                 32'h0000CAFE, 32'h0000BEEF, 32'h0000CAFE, 32'h0000BEEF, 0, 32'h0, 32'h0000CAFE, 0);

    // Reset and init sequence
    rst = 1'b1;
    idle_writes();
    raddr = '0;
    tick();
    check("reset ready", 128'(ready), 128'(0));
    check("reset rdata", 128'(rdata), 128'(0));
    check("reset conflict", 128'(conf), 128'(0));
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      if (n == 5) begin
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hBEEF;
        raddr = lanes(3, 3, 1, 2);
        #1;
        check("init rdata forced 0", 128'(rdata), 128'(0));
        check("init conflict 0", 128'(conf), 128'(0));
        check("init nz rdata forced 0", 128'(rdata_nz), 128'(0));
      end
      tick();
      if (n == 5) idle_writes();
      n++;
    end
    check("init cycles to ready", 128'(n), 128'(32));
    check("nb ready", 128'(ready_nb), 128'(1));
    check("nz ready", 128'(ready_nz), 128'(1));

    for (int a = 0; a < 32; a += 4) begin
      raddr = lanes(a, a + 1, a + 2, a + 3);
      #1;
      check($sformatf("cleared %0d..%0d", a, a + 3), 128'(rdata), 128'(0));
      check($sformatf("nz cleared %0d..%0d", a, a + 3), 128'(rdata_nz), 128'(0));
    end

    // Table-driven run-mode vectors
    for (int i = 0; i < NV; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      raddr = vecs[i].ra;
      #1;
      check($sformatf("v%0d rdata", i), 128'(rdata), 128'(vecs[i].exp_rd));
      check($sformatf("v%0d conflict", i), 128'(conf), 128'(vecs[i].exp_conf));
      check($sformatf("v%0d nobypass lane0", i), 128'(rdata_nb[DW-1:0]), 128'(vecs[i].exp_nb0));
      check($sformatf("v%0d nozero lane0", i), 128'(rdata_nz[DW-1:0]), 128'(vecs[i].exp_nz0));
      check($sformatf("v%0d nozero conflict", i), 128'(conf_nz), 128'(vecs[i].exp_nz_conf));
      tick();
    end
    idle_writes();

    // Reset in RUN re-enters INIT and clears written data
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1234;
    tick();
    idle_writes();
    raddr = lanes(4, 0, 0, 0);
    #1;
    check("run write 4", 128'(rdata[DW-1:0]), 128'(32'h1234));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("run reset ready low", 128'(ready), 128'(0));
    check("run reset rdata 0", 128'(rdata), 128'(0));
    wait_ready(n);
    check("run reset cycles to ready", 128'(n), 128'(32));
    raddr = lanes(4, 10, 11, 9);
    #1;
    check("entry 4 cleared", 128'(rdata), 128'(0));

    // Reset mid-init restarts the clear count
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("mid init ready low", 128'(ready), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    check("mid init cycles to ready", 128'(n), 128'(32));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
